// File: rtl/fpga_cfg_pkg.sv
// Shared constants and FSM encoding for the FPGA configuration loader.
// The checksum stage is compiled in only when FPGA_CFG_CHECKSUM_EN is defined.
package fpga_cfg_pkg;

   localparam logic [7:0] HDR_FRAME = 8'hA5;
   localparam logic [7:0] HDR_END   = 8'h5A;

   localparam int unsigned TILE_BYTES = 5;
   localparam int unsigned SW_BYTES   = 2;
   localparam int unsigned TILE_CFG_W = 33;
   localparam int unsigned SW_CFG_W   = 16;

   typedef logic [2:0] state_t;

   localparam state_t StHunt    = 3'd0;
   localparam state_t StIndex   = 3'd1;
   localparam state_t StPayload = 3'd2;
   localparam state_t StCheck   = 3'd3;
   localparam state_t StCommit  = 3'd4;
   localparam state_t StDone    = 3'd5;
   localparam state_t StError   = 3'd6;

   // Counter value of the final payload byte for the selected target type.
   function automatic logic [2:0] payload_last(input logic is_sw);
      return is_sw ? 3'(SW_BYTES - 1) : 3'(TILE_BYTES - 1);
   endfunction

endpackage

// File: rtl/fpga_cfg_if.sv
// Configuration byte stream plus element write port of the configuration loader.
// master = stream source / write consumer, slave = the loader.
interface fpga_cfg_if;
   import fpga_cfg_pkg::*;

   logic                  cfg_valid;
   logic [7:0]            cfg_data;
   logic                  cfg_ready;
   logic                  cfg_clear;
   logic                  wr_en;
   logic                  wr_is_sw;
   logic [6:0]            wr_idx;
   logic [TILE_CFG_W-1:0] wr_data;
   logic                  cfg_done;
   logic                  cfg_err;
   logic [7:0]            frame_count;

   modport master (
      output cfg_valid, cfg_data, cfg_clear,
      input  cfg_ready, wr_en, wr_is_sw, wr_idx, wr_data, cfg_done, cfg_err, frame_count
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_clear,
      output cfg_ready, wr_en, wr_is_sw, wr_idx, wr_data, cfg_done, cfg_err, frame_count
   );

endinterface

// File: rtl/fpga_cfg_assembler.sv
// Payload assembly: little-endian byte shift-in, byte counter and running XOR checksum.
// clear_i loads the index byte (seeds the checksum and selects the payload length).
module fpga_cfg_assembler
   import fpga_cfg_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  shift_i,
   input  logic [7:0]            byte_i,
   output logic [TILE_CFG_W-1:0] word_o,
   output logic                  last_o,
   output logic [7:0]            csum_o
);

   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            last_idx_q, last_idx_d;
   logic [TILE_CFG_W-1:0] word_q, word_d;
   logic [7:0]            csum_q, csum_d;

   always_comb begin
      cnt_d      = cnt_q;
      last_idx_d = last_idx_q;
      word_d     = word_q;
      csum_d     = csum_q;
      if (clear_i) begin
         cnt_d      = 3'd0;
         last_idx_d = payload_last(byte_i[7]);
         word_d     = '0;
         csum_d     = byte_i;
      end else if (shift_i) begin
         cnt_d  = cnt_q + 3'd1;
         csum_d = csum_q ^ byte_i;
         case (cnt_q)
            3'd0:    word_d[7:0]   = byte_i;
            3'd1:    word_d[15:8]  = byte_i;
            3'd2:    word_d[23:16] = byte_i;
            3'd3:    word_d[31:24] = byte_i;
            // Fifth tile byte carries only the registered/combinational select bit.
            default: word_d[TILE_CFG_W-1] = byte_i[0];
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= 3'd0;
         last_idx_q <= 3'd0;
         word_q     <= '0;
         csum_q     <= 8'h00;
      end else begin
         cnt_q      <= cnt_d;
         last_idx_q <= last_idx_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
      end
   end

   // Word includes the byte being shifted this cycle so a commit can capture it directly.
   assign word_o = word_d;
   assign last_o = (cnt_q == last_idx_q);
   assign csum_o = csum_q;

endmodule

// File: rtl/fpga_config_loader.sv
// Framed configuration byte-stream loader driving tile / switch-box write strobes.
// Optional checksum byte per frame enabled by defining FPGA_CFG_CHECKSUM_EN.
module fpga_config_loader
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned NUM_TILES  = 24,
   parameter int unsigned NUM_SWITCH = 9
) (
   input  logic        clock,
   input  logic        reset_n,
   fpga_cfg_if.slave   cfg_bus
);

   localparam logic [7:0] TileLimit = 8'(NUM_TILES);
   localparam logic [7:0] SwLimit   = 8'(NUM_SWITCH);

   state_t                state_q, state_d;
   logic                  tgt_sw_q, tgt_sw_d;
   logic [6:0]            tgt_idx_q, tgt_idx_d;
   logic                  wr_en_q, wr_en_d;
   logic                  wr_is_sw_q, wr_is_sw_d;
   logic [6:0]            wr_idx_q, wr_idx_d;
   logic [TILE_CFG_W-1:0] wr_data_q, wr_data_d;
   logic [7:0]            fcnt_q, fcnt_d;

   logic                  accept;
   logic                  idx_ok;
   logic                  commit;
   logic                  asm_clear;
   logic                  asm_shift;
   logic                  asm_last;
   logic [TILE_CFG_W-1:0] asm_word;
`ifdef FPGA_CFG_CHECKSUM_EN
   logic [7:0]            asm_csum;
`endif

   assign accept = cfg_bus.cfg_valid && cfg_bus.cfg_ready;
   assign idx_ok = cfg_bus.cfg_data[7] ? ({1'b0, cfg_bus.cfg_data[6:0]} < SwLimit)
                                       : ({1'b0, cfg_bus.cfg_data[6:0]} < TileLimit);

   always_comb begin
      state_d   = state_q;
      tgt_sw_d  = tgt_sw_q;
      tgt_idx_d = tgt_idx_q;
      asm_clear = 1'b0;
      asm_shift = 1'b0;
      commit    = 1'b0;
      case (state_q)
         StHunt: begin
            if (accept) begin
               if (cfg_bus.cfg_data == HDR_FRAME)    state_d = StIndex;
               else if (cfg_bus.cfg_data == HDR_END) state_d = StDone;
            end
         end
         StIndex: begin
            if (accept) begin
               if (idx_ok) begin
                  tgt_sw_d  = cfg_bus.cfg_data[7];
                  tgt_idx_d = cfg_bus.cfg_data[6:0];
                  asm_clear = 1'b1;
                  state_d   = StPayload;
               end else begin
                  state_d = StError;
               end
            end
         end
         StPayload: begin
            if (accept) begin
               asm_shift = 1'b1;
               if (asm_last) begin
`ifdef FPGA_CFG_CHECKSUM_EN
                  state_d = StCheck;
`else
                  state_d = StCommit;
                  commit  = 1'b1;
`endif
               end
            end
         end
`ifdef FPGA_CFG_CHECKSUM_EN
         StCheck: begin
            if (accept) begin
               if (cfg_bus.cfg_data == asm_csum) begin
                  state_d = StCommit;
                  commit  = 1'b1;
               end else begin
                  state_d = StError;
               end
            end
         end
`endif
         StCommit: state_d = StHunt;
         StDone:   if (cfg_bus.cfg_clear) state_d = StHunt;
         StError:  if (cfg_bus.cfg_clear) state_d = StHunt;
         default:  state_d = StHunt;
      endcase
   end

   // Write outputs are captured on the edge that enters COMMIT and hold until the next commit.
   always_comb begin
      wr_en_d    = commit;
      wr_is_sw_d = commit ? tgt_sw_q  : wr_is_sw_q;
      wr_idx_d   = commit ? tgt_idx_q : wr_idx_q;
      wr_data_d  = commit ? asm_word  : wr_data_q;
      fcnt_d     = fcnt_q;
      if (commit && (fcnt_q != 8'hFF)) begin
         fcnt_d = fcnt_q + 8'd1;
      end else if ((state_q == StDone) && cfg_bus.cfg_clear) begin
         fcnt_d = 8'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StHunt;
         tgt_sw_q   <= 1'b0;
         tgt_idx_q  <= 7'd0;
         wr_en_q    <= 1'b0;
         wr_is_sw_q <= 1'b0;
         wr_idx_q   <= 7'd0;
         wr_data_q  <= '0;
         fcnt_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         tgt_sw_q   <= tgt_sw_d;
         tgt_idx_q  <= tgt_idx_d;
         wr_en_q    <= wr_en_d;
         wr_is_sw_q <= wr_is_sw_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         fcnt_q     <= fcnt_d;
      end
   end

   fpga_cfg_assembler u_assembler (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .clear_i (asm_clear),
      .shift_i (asm_shift),
      .byte_i  (cfg_bus.cfg_data),
      .word_o  (asm_word),
      .last_o  (asm_last),
`ifdef FPGA_CFG_CHECKSUM_EN
      .csum_o  (asm_csum)
`else
      .csum_o  ()
`endif
   );

   assign cfg_bus.cfg_ready   = (state_q == StHunt) || (state_q == StIndex) ||
                                (state_q == StPayload) || (state_q == StCheck);
   assign cfg_bus.wr_en       = wr_en_q;
   assign cfg_bus.wr_is_sw    = wr_is_sw_q;
   assign cfg_bus.wr_idx      = wr_idx_q;
   assign cfg_bus.wr_data     = wr_data_q;
   assign cfg_bus.cfg_done    = (state_q == StDone);
   assign cfg_bus.cfg_err     = (state_q == StError);
   assign cfg_bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader; follows FPGA_CFG_CHECKSUM_EN to frame bytes.
module tb_fpga_config_loader;

   logic clock;
   logic reset_n;
   int   n_cmp;
   int   n_err;
   int   wr_count;

   fpga_cfg_if bus ();

   fpga_config_loader #(
      .NUM_TILES  (24),
      .NUM_SWITCH (9)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .cfg_bus (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Each wr_en pulse spans one full cycle, so one negedge sample per pulse.
   always @(negedge clock) if (bus.wr_en === 1'b1) wr_count++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clock);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = b;
      while (!bus.cfg_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!bus.cfg_ready) begin
         check("ready_timeout", {63'd0, bus.cfg_ready}, 64'd1);
         bus.cfg_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1 bus.cfg_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] idx, input logic [39:0] pl, input int len,
                             input bit gaps);
`ifdef FPGA_CFG_CHECKSUM_EN
      logic [7:0] cs;
      cs = idx;
`endif
      send_byte(8'hA5);
      if (gaps) idle($urandom_range(0, 3));
      send_byte(idx);
      for (int i = 0; i < len; i++) begin
         if (gaps) idle($urandom_range(0, 3));
         send_byte(pl[i*8 +: 8]);
`ifdef FPGA_CFG_CHECKSUM_EN
         cs = cs ^ pl[i*8 +: 8];
`endif
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      if (gaps) idle($urandom_range(0, 3));
      send_byte(cs);
`endif
   endtask

   task automatic pulse_clear();
      @(negedge clock);
      bus.cfg_clear = 1'b1;
      @(posedge clock);
      #1 bus.cfg_clear = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_ready"}, {63'd0, bus.cfg_ready}, 64'd1);
      check({pfx, "_wr_en"}, {63'd0, bus.wr_en}, 64'd0);
      check({pfx, "_is_sw"}, {63'd0, bus.wr_is_sw}, 64'd0);
      check({pfx, "_idx"}, {57'd0, bus.wr_idx}, 64'd0);
      check({pfx, "_data"}, {31'd0, bus.wr_data}, 64'd0);
      check({pfx, "_done"}, {63'd0, bus.cfg_done}, 64'd0);
      check({pfx, "_err"}, {63'd0, bus.cfg_err}, 64'd0);
      check({pfx, "_fcnt"}, {56'd0, bus.frame_count}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc;
      n_cmp = 0; n_err = 0; wr_count = 0;
      reset_n = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 8'h00;
      bus.cfg_clear = 1'b0;
      idle(3);
      @(negedge clock);
      check_reset_values("rst");
      reset_n = 1'b1;

      // Tile 3 = 0x1_DEADBEEF
      send_frame(8'h03, 40'h01_DEADBEEF, 5, 1'b0);
      check("tile_wr_en", {63'd0, bus.wr_en}, 64'd1);
      check("tile_ready_bubble", {63'd0, bus.cfg_ready}, 64'd0);
      check("tile_is_sw", {63'd0, bus.wr_is_sw}, 64'd0);
      check("tile_idx", {57'd0, bus.wr_idx}, 64'd3);
      check("tile_data", {31'd0, bus.wr_data}, 64'h1_DEADBEEF);
      check("tile_fcnt", {56'd0, bus.frame_count}, 64'd1);
      @(posedge clock); #1;
      check("tile_wr_en_drop", {63'd0, bus.wr_en}, 64'd0);
      check("tile_data_hold", {31'd0, bus.wr_data}, 64'h1_DEADBEEF);
      check("tile_wr_count", wr_count, 64'd1);

      // Switch box 2 = 0x1234, then end marker
      send_frame(8'h82, 40'h00_00001234, 2, 1'b0);
      check("sw_wr_en", {63'd0, bus.wr_en}, 64'd1);
      check("sw_is_sw", {63'd0, bus.wr_is_sw}, 64'd1);
      check("sw_idx", {57'd0, bus.wr_idx}, 64'd2);
      check("sw_data", {31'd0, bus.wr_data}, 64'h0_00001234);
      check("sw_fcnt", {56'd0, bus.frame_count}, 64'd2);
      send_byte(8'h5A);
      check("done_rise", {63'd0, bus.cfg_done}, 64'd1);
      check("done_ready", {63'd0, bus.cfg_ready}, 64'd0);
      idle(3); #1;
      check("done_hold", {63'd0, bus.cfg_done}, 64'd1);
      check("done_wr_count", wr_count, 64'd2);
      pulse_clear();
      check("done_clear_done", {63'd0, bus.cfg_done}, 64'd0);
      check("done_clear_fcnt", {56'd0, bus.frame_count}, 64'd0);
      check("done_clear_ready", {63'd0, bus.cfg_ready}, 64'd1);

      // Highest legal tile; byte 4 bits[7:1] are dropped
      send_frame(8'h17, 40'hFF_00000000, 5, 1'b0);
      check("tmax_idx", {57'd0, bus.wr_idx}, 64'd23);
      check("tmax_data", {31'd0, bus.wr_data}, 64'h1_00000000);
      check("tmax_fcnt", {56'd0, bus.frame_count}, 64'd1);
      wc = wr_count + 1;

`ifdef FPGA_CFG_CHECKSUM_EN
      send_byte(8'hA5); send_byte(8'h03);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE); send_byte(8'h01);
      send_byte(8'h21);
      check("csum_err", {63'd0, bus.cfg_err}, 64'd1);
      check("csum_no_wr", {63'd0, bus.wr_en}, 64'd0);
      check("csum_ready", {63'd0, bus.cfg_ready}, 64'd0);
      idle(2);
      check("csum_wr_count", wr_count, wc);
      pulse_clear();
      check("csum_clear_err", {63'd0, bus.cfg_err}, 64'd0);
      check("csum_clear_ready", {63'd0, bus.cfg_ready}, 64'd1);
      check("csum_fcnt_kept", {56'd0, bus.frame_count}, 64'd1);
`endif

      // Tile index 24 is out of range; loader stops accepting
      send_byte(8'hA5); send_byte(8'h18);
      check("bidx_err", {63'd0, bus.cfg_err}, 64'd1);
      check("bidx_ready", {63'd0, bus.cfg_ready}, 64'd0);
      @(negedge clock);
      bus.cfg_valid = 1'b1; bus.cfg_data = 8'h01;
      repeat (3) @(negedge clock);
      check("bidx_err_hold", {63'd0, bus.cfg_err}, 64'd1);
      check("bidx_ready_hold", {63'd0, bus.cfg_ready}, 64'd0);
      bus.cfg_valid = 1'b0;
      pulse_clear();
      check("bidx_fcnt_kept", {56'd0, bus.frame_count}, 64'd1);

      // Switch index 9 is out of range; 8 is legal
      send_byte(8'hA5); send_byte(8'h89);
      check("bsw_err", {63'd0, bus.cfg_err}, 64'd1);
      pulse_clear();
      send_frame(8'h88, 40'h00_0000BEEF, 2, 1'b0);
      check("swmax_idx", {57'd0, bus.wr_idx}, 64'd8);
      check("swmax_data", {31'd0, bus.wr_data}, 64'h0_0000BEEF);
      check("swmax_fcnt", {56'd0, bus.frame_count}, 64'd2);

      // Garbage then a gapped frame
      idle(1); #1;
      wc = wr_count;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
      send_frame(8'h05, 40'h00_CAFEF00D, 5, 1'b1);
      check("gap_wr_en", {63'd0, bus.wr_en}, 64'd1);
      check("gap_idx", {57'd0, bus.wr_idx}, 64'd5);
      check("gap_data", {31'd0, bus.wr_data}, 64'h0_CAFEF00D);
      idle(2);
      check("gap_wr_count", wr_count, wc + 1);
      check("gap_fcnt", {56'd0, bus.frame_count}, 64'd3);

      // Reset after the third payload byte
      wc = wr_count;
      send_byte(8'hA5); send_byte(8'h07);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      idle(2);
      @(negedge clock);
      reset_n = 1'b1;
      idle(2);
      check("mid_rst_no_wr", wr_count, wc);
      send_frame(8'h07, 40'h00_44332211, 5, 1'b0);
      check("post_rst_wr_en", {63'd0, bus.wr_en}, 64'd1);
      check("post_rst_idx", {57'd0, bus.wr_idx}, 64'd7);
      check("post_rst_data", {31'd0, bus.wr_data}, 64'h0_44332211);
      check("post_rst_fcnt", {56'd0, bus.frame_count}, 64'd1);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
